// File: rtl/ram32_sdram_pkg.sv
// ---------------------------------------------------------------------------
// ram32_sdram_pkg
// Shared definitions for the 32x8 three-strobe SDRAM controller and its
// memory array: controller state encoding, address field slices and the
// default address/data widths.
// Address layout (5 bits): v = [4:3], r = [2:1], c = [0].
// ---------------------------------------------------------------------------
package ram32_sdram_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam int V_HI  = 4;
  localparam int V_LO  = 3;
  localparam int R_HI  = 2;
  localparam int R_LO  = 1;
  localparam int C_BIT = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VAS  = 3'd1,
    RAS  = 3'd2,
    CAS  = 3'd3,
    ACC  = 3'd4,
    CAPT = 3'd5
  } state_e;

  // Vertical field of a word address.
  function automatic logic [1:0] v_field(input logic [ADDR_W_DEF-1:0] addr);
    return addr[V_HI:V_LO];
  endfunction

  // Row field of a word address.
  function automatic logic [1:0] r_field(input logic [ADDR_W_DEF-1:0] addr);
    return addr[R_HI:R_LO];
  endfunction

endpackage

// File: rtl/ram32_sdram_3split.sv
// ---------------------------------------------------------------------------
// ram32_sdram_3split
// 32x8 memory array addressed through three active-low strobes. Each strobe
// latches its own address field; an access (en=1) uses the latched fields.
// Read data is registered and is 0 in any cycle not preceded by a read access.
// Array contents survive reset; only the field latches and read data clear.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   en, rw             access enable, 1 = write / 0 = read
//   vas, ras, cas      active-low field strobes (v, r, c)
//   address            address bus sampled by the strobes
//   datain             write data
//   dataout            registered read data
// ---------------------------------------------------------------------------
module ram32_sdram_3split
  import ram32_sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rw,
  input  logic              vas,
  input  logic              ras,
  input  logic              cas,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [1:0]        row_v;
  logic [1:0]        row_r;
  logic              col_c;
  logic [ADDR_W-1:0] acc_addr;

  assign acc_addr = {row_v, row_r, col_c};

  // Field latches and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_v   <= 2'b00;
      row_r   <= 2'b00;
      col_c   <= 1'b0;
      dataout <= '0;
    end else begin
      if (!vas) begin
        row_v <= address[V_HI:V_LO];
      end
      if (!ras) begin
        row_r <= address[R_HI:R_LO];
      end
      if (!cas) begin
        col_c <= address[C_BIT];
      end
      if (en && !rw) begin
        dataout <= mem[acc_addr];
      end else begin
        dataout <= '0;
      end
    end
  end

  // Array write port; deliberately not reset so data survives a controller abort.
  always_ff @(posedge clk) begin
    if (en && rw) begin
      mem[acc_addr] <= datain;
    end
  end

endmodule

// File: rtl/ram32_sdram_3split_ctrl.sv
// ---------------------------------------------------------------------------
// ram32_sdram_3split_ctrl
// Upstream controller for the three-strobe SDRAM array. Accepts one
// valid/ready request at a time, walks the VAS -> RAS -> CAS strobe cycles,
// performs the access and returns a one-cycle response pulse. The vertical
// and row fields last strobed are remembered so a request that hits the open
// fields skips the matching strobe (when PAGE_KEEP = 1).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata   request fields, latched on accept
//   rsp_valid/rsp_we/rsp_rdata  one-cycle completion pulse and read data
//   mem_en/mem_rw               access enable and direction (ACC only)
//   mem_vas/mem_ras/mem_cas     active-low field strobes
//   mem_address/mem_datain      latched address and write data
//   mem_dataout                 registered read data from the array
// ---------------------------------------------------------------------------
module ram32_sdram_3split_ctrl
  import ram32_sdram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit PAGE_KEEP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic              mem_vas,
  output logic              mem_ras,
  output logic              mem_cas,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  state_e            state;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        open_v;
  logic [1:0]        open_r;
  logic              v_seen;
  logic              r_seen;
  logic              open_valid;
  logic              req_v_hit;
  logic              req_r_hit;
  logic              lat_r_hit;

  // The open fields only mean something once both strobes have run since reset.
  assign open_valid = v_seen && r_seen;

  // Hit tests: incoming request (from IDLE) and latched request (from VAS).
  assign req_v_hit = PAGE_KEEP && open_valid && (v_field(req_addr) == open_v);
  assign req_r_hit = PAGE_KEEP && open_valid && (r_field(req_addr) == open_r);
  assign lat_r_hit = PAGE_KEEP && open_valid && (r_field(lat_addr) == open_r);

  // Address and data buses come straight from the request latches, so they
  // are stable from the first strobe through the access cycle.
  assign mem_address = lat_addr;
  assign mem_datain  = lat_wdata;

  // Sequencer: request latch, open-page tracking and response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      open_v    <= 2'b00;
      open_r    <= 2'b00;
      v_seen    <= 1'b0;
      r_seen    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_addr  <= req_addr;
            lat_we    <= req_we;
            lat_wdata <= req_wdata;
            if (!req_v_hit) begin
              state <= VAS;
            end else if (!req_r_hit) begin
              state <= RAS;
            end else begin
              state <= CAS;
            end
          end
        end
        VAS: begin
          open_v <= v_field(lat_addr);
          v_seen <= 1'b1;
          state  <= lat_r_hit ? CAS : RAS;
        end
        RAS: begin
          open_r <= r_field(lat_addr);
          r_seen <= 1'b1;
          state  <= CAS;
        end
        CAS: begin
          state <= ACC;
        end
        ACC: begin
          if (lat_we) begin
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end else begin
            // Array read data is registered, so it appears one cycle later.
            state <= CAPT;
          end
        end
        CAPT: begin
          rsp_valid <= 1'b1;
          rsp_we    <= 1'b0;
          rsp_rdata <= mem_dataout;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode of handshake and memory controls from the state register.
  always_comb begin
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_vas   = 1'b1;
    mem_ras   = 1'b1;
    mem_cas   = 1'b1;
    case (state)
      IDLE:    req_ready = 1'b1;
      VAS:     mem_vas   = 1'b0;
      RAS:     mem_ras   = 1'b0;
      CAS:     mem_cas   = 1'b0;
      ACC: begin
        mem_en = 1'b1;
        mem_rw = lat_we;
      end
      CAPT:    mem_en    = 1'b0;
      default: mem_en    = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ram32_sdram_3split_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram32_sdram_3split_ctrl
// Two controller+array pairs: dut1 with open-page reuse, dut0 without.
// Requests are steered to one pair at a time by 'sel'. A behavioural model
// (memory image plus open v/r fields per pair) predicts latency, strobe
// order and read data.
// ---------------------------------------------------------------------------
module tb_ram32_sdram_3split_ctrl;
  import ram32_sdram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid;
  logic       req_we;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  bit         sel;

  logic       rv1, ready1, rspv1, rspwe1, en1, rw1, vas1, ras1, cas1;
  logic       rv0, ready0, rspv0, rspwe0, en0, rw0, vas0, ras0, cas0;
  logic [7:0] rd1, rd0, din1, din0, dout1, dout0;
  logic [4:0] addr1, addr0;

  assign rv1 = req_valid & sel;
  assign rv0 = req_valid & ~sel;

  ram32_sdram_3split_ctrl #(.ADDR_W(5), .DATA_W(8), .PAGE_KEEP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv1), .rsp_we(rspwe1),
    .rsp_rdata(rd1), .mem_en(en1), .mem_rw(rw1), .mem_vas(vas1), .mem_ras(ras1),
    .mem_cas(cas1), .mem_address(addr1), .mem_datain(din1), .mem_dataout(dout1));
  ram32_sdram_3split #(.ADDR_W(5), .DATA_W(8)) mem1 (
    .clk(clk), .rst(rst), .en(en1), .rw(rw1), .vas(vas1), .ras(ras1), .cas(cas1),
    .address(addr1), .datain(din1), .dataout(dout1));

  ram32_sdram_3split_ctrl #(.ADDR_W(5), .DATA_W(8), .PAGE_KEEP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv0), .rsp_we(rspwe0),
    .rsp_rdata(rd0), .mem_en(en0), .mem_rw(rw0), .mem_vas(vas0), .mem_ras(ras0),
    .mem_cas(cas0), .mem_address(addr0), .mem_datain(din0), .mem_dataout(dout0));
  ram32_sdram_3split #(.ADDR_W(5), .DATA_W(8)) mem0 (
    .clk(clk), .rst(rst), .en(en0), .rw(rw0), .vas(vas0), .ras(ras0), .cas(cas0),
    .address(addr0), .datain(din0), .dataout(dout0));

  logic       m_ready, m_rspv, m_rspwe, m_en, m_rw, m_vas, m_ras, m_cas;
  logic [7:0] m_rd, m_din;
  logic [4:0] m_addr;
  assign m_ready = sel ? ready1 : ready0;
  assign m_rspv  = sel ? rspv1  : rspv0;
  assign m_rspwe = sel ? rspwe1 : rspwe0;
  assign m_rd    = sel ? rd1    : rd0;
  assign m_en    = sel ? en1    : en0;
  assign m_rw    = sel ? rw1    : rw0;
  assign m_vas   = sel ? vas1   : vas0;
  assign m_ras   = sel ? ras1   : ras0;
  assign m_cas   = sel ? cas1   : cas0;
  assign m_addr  = sel ? addr1  : addr0;
  assign m_din   = sel ? din1   : din0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mm [0:1][0:31];
  logic [1:0] ov [0:1];
  logic [1:0] orw [0:1];
  bit         vs [0:1];
  bit         rs [0:1];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      vs[i] = 1'b0;
      rs[i] = 1'b0;
    end
  endfunction

  // Strobe order is encoded as decimal digits: 1=VAS 2=RAS 3=CAS 4=ACC.
  function automatic void model_step(input bit s, input bit we, input logic [4:0] a,
                                     input logic [7:0] wd, output int elat,
                                     output int epat, output logic [7:0] erd);
    bit ovld, sk_v, sk_r;
    ovld = vs[s] && rs[s];
    sk_v = s && ovld && (ov[s] == a[4:3]);
    sk_r = s && ovld && (orw[s] == a[2:1]);
    epat = 0;
    elat = 3;
    if (!sk_v) begin
      epat = 1; elat++; ov[s] = a[4:3]; vs[s] = 1'b1;
    end
    if (!sk_r) begin
      epat = epat * 10 + 2; elat++; orw[s] = a[2:1]; rs[s] = 1'b1;
    end
    epat = epat * 100 + 34;
    if (!we) elat++;
    if (we) begin
      mm[s][a] = wd; erd = 8'h00;
    end else begin
      erd = mm[s][a];
    end
  endfunction

  // ---------------- transaction driver ----------------
  task automatic do_txn(input bit we, input logic [4:0] a, input logic [7:0] wd,
                        output int lat, output int pat, output int acc_at,
                        output logic [7:0] rd, output logic rwe, output bit ok);
    int guard;
    int lows;
    lat = 0; pat = 0; acc_at = 0; rd = 8'h00; rwe = 1'b0; ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!m_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!m_ready) begin
      req_valid = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 5'($urandom_range(0, 31));
    req_wdata = 8'($urandom_range(0, 255));
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      lows = int'(!m_vas) + int'(!m_ras) + int'(!m_cas);
      chk("single_strobe", 32'(lows <= 1), 32'd1);
      if (lows != 0 || m_en) begin
        chk("addr_stable", 32'(m_addr), 32'(a));
        if (we) chk("datain_stable", 32'(m_din), 32'(wd));
      end
      if (m_en) chk("mem_rw_acc", 32'(m_rw), 32'(we));
      else      chk("mem_rw_quiet", 32'(m_rw), 32'd0);
      if (!m_vas)      pat = pat * 10 + 1;
      else if (!m_ras) pat = pat * 10 + 2;
      else if (!m_cas) pat = pat * 10 + 3;
      else if (m_en) begin
        pat = pat * 10 + 4;
        acc_at = n;
      end
      if (m_rspv) begin
        lat = n; rd = m_rd; rwe = m_rspwe; ok = 1'b1;
        chk("ready_with_rsp", 32'(m_ready), 32'd1);
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      chk("rsp_one_cycle", 32'(m_rspv), 32'd0);
    end
  endtask

  task automatic model_txn(input bit s, input bit we, input logic [4:0] a, input logic [7:0] wd);
    int elat, epat, lat, pat, acc_at;
    logic [7:0] erd, rd;
    logic rwe;
    bit ok;
    sel = s;
    model_step(s, we, a, wd, elat, epat, erd);
    do_txn(we, a, wd, lat, pat, acc_at, rd, rwe, ok);
    chk("m_latency", 32'(lat), 32'(elat));
    chk("m_strobes", 32'(pat), 32'(epat));
    chk("m_acc_cycle", 32'(acc_at), 32'(we ? elat - 1 : elat - 2));
    chk("m_rsp_we", 32'(rwe), 32'(we));
    chk("m_rdata", 32'(rd), 32'(erd));
  endtask

  typedef struct {
    bit         s;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         exp_lat;
    int         exp_pat;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [0:9];

  initial begin
    int lat, pat, acc_at, elat, epat, got_ras, k, acc_n, pulses, b2b;
    logic [7:0] rd, erd;
    logic rwe;
    bit ok;
    bit         bw  [0:3];
    logic [4:0] ba  [0:3];
    logic [7:0] bd  [0:3];
    logic [7:0] exp_q [$];
    bit         expw_q [$];
    logic [4:0] prev_addr;

    vecs[0] = '{1'b1, 1'b1, 5'h13, 8'hA5, 5, 1234, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 5'h13, 8'h00, 4,   34, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 5'h00, 8'h11, 5, 1234, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 5'h1F, 8'hEE, 5, 1234, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 5'h00, 8'h00, 6, 1234, 8'h11};
    vecs[5] = '{1'b0, 1'b0, 5'h1F, 8'h00, 6, 1234, 8'hEE};
    vecs[6] = '{1'b1, 1'b1, 5'h02, 8'h5A, 4,  134, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 5'h0A, 8'hC3, 4,  134, 8'h00};
    vecs[8] = '{1'b1, 1'b0, 5'h02, 8'h00, 5,  134, 8'h5A};
    vecs[9] = '{1'b1, 1'b0, 5'h0A, 8'h00, 5,  134, 8'hC3};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 5'h00; req_wdata = 8'h00;
    sel = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(m_ready), 32'd1);
    chk("rst_ready0", 32'(ready0), 32'd1);
    chk("rst_rsp_valid", 32'(m_rspv), 32'd0);
    chk("rst_rsp_we", 32'(m_rspwe), 32'd0);
    chk("rst_rsp_rdata", 32'(m_rd), 32'd0);
    chk("rst_mem_en", 32'(m_en), 32'd0);
    chk("rst_mem_rw", 32'(m_rw), 32'd0);
    chk("rst_strobes", 32'({m_vas, m_ras, m_cas}), 32'h7);
    chk("rst_address", 32'(m_addr), 32'd0);
    chk("rst_datain", 32'(m_din), 32'd0);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      sel = vecs[i].s;
      model_step(vecs[i].s, vecs[i].we, vecs[i].addr, vecs[i].wdata, elat, epat, erd);
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, pat, acc_at, rd, rwe, ok);
      chk("v_latency", 32'(lat), 32'(vecs[i].exp_lat));
      chk("v_strobes", 32'(pat), 32'(vecs[i].exp_pat));
      chk("v_acc_cycle", 32'(acc_at),
          32'(vecs[i].we ? vecs[i].exp_lat - 1 : vecs[i].exp_lat - 2));
      chk("v_rsp_we", 32'(rwe), 32'(vecs[i].we));
      chk("v_rdata", 32'(rd), 32'(vecs[i].exp_rdata));
    end

    // Initialise both arrays to zero
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 32; a++)
        model_txn(s[0], 1'b1, 5'(a), 8'h00);

    // Reset during RAS of a write
    model_txn(1'b1, 1'b0, 5'h00, 8'h00);
    sel = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(m_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h07; req_wdata = 8'h3C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got_ras = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!m_ras) begin
        got_ras = 1;
        break;
      end
    end
    chk("abort_reach_ras", 32'(got_ras), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(m_rspv), 32'd0);
    end
    model_txn(1'b1, 1'b0, 5'h07, 8'h00);

    // Held request, four alternating transactions back to back
    bw[0] = 1'b1; ba[0] = 5'h05; bd[0] = 8'h77;
    bw[1] = 1'b0; ba[1] = 5'h05; bd[1] = 8'h00;
    bw[2] = 1'b1; ba[2] = 5'h1A; bd[2] = 8'h99;
    bw[3] = 1'b0; ba[3] = 5'h1A; bd[3] = 8'h00;
    sel = 1'b1; k = 0; acc_n = 0; pulses = 0; b2b = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      chk("b2b_single_strobe",
          32'((int'(!m_vas) + int'(!m_ras) + int'(!m_cas)) <= 1), 32'd1);
      if (m_rspv) begin
        pulses++;
        if (exp_q.size() > 0) begin
          chk("b2b_rsp_we", 32'(m_rspwe), 32'(expw_q.pop_front()));
          chk("b2b_rdata", 32'(m_rd), 32'(exp_q.pop_front()));
        end else begin
          chk("b2b_extra_rsp", 32'd1, 32'd0);
        end
        if (m_ready && k < 4) b2b++;
      end
      if (k < 4) begin
        req_valid = 1'b1; req_we = bw[k]; req_addr = ba[k]; req_wdata = bd[k];
        if (m_ready) begin
          model_step(1'b1, bw[k], ba[k], bd[k], elat, epat, erd);
          exp_q.push_back(erd);
          expw_q.push_back(bw[k]);
          k++;
          acc_n++;
        end
      end else begin
        req_valid = 1'b0;
      end
      if (k == 4 && pulses == 4) break;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_n), 32'd4);
    chk("b2b_pulses", 32'(pulses), 32'd4);
    chk("b2b_overlap", 32'(b2b), 32'd3);
    repeat (8) begin
      @(negedge clk);
      chk("b2b_quiet", 32'(m_rspv), 32'd0);
    end

    // Randomised traffic on both pairs, biased toward page reuse
    prev_addr = 5'h00;
    for (int i = 0; i < 80; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) a[4:1] = prev_addr[4:1];
      prev_addr = a;
      model_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram32_sdram_3split_ctrl.md
Name: ram32_sdram_3split_ctrl

Overview:
- Upstream controller for the 32x8 three-strobe SDRAM array (vertical/row/column strobes, active-low).
- Accepts simple valid/ready read/write requests and sequences the strobe cycles, then the access cycle.
- Returns read data as a one-cycle response pulse.
- Tracks the currently latched vertical and row fields, so repeat accesses skip redundant strobes ("page hit").

Parameters:
- ADDR_W, 5, request/memory address width; field split fixed as v=[4:3], r=[2:1], c=[0].
- DATA_W, 8, data width.
- PAGE_KEEP, 1, 1 = skip VAS/RAS when the field matches the open field; 0 = always run the full sequence.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse per completed request (read or write).
- rsp_we  out  1  echo of req_we for the completing request.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid when rsp_we=0, otherwise 0.
- mem_en  out  1  memory enable; high only in ACC.
- mem_rw  out  1  0 = read, 1 = write; equals latched we in ACC, otherwise 0.
- mem_vas, mem_ras, mem_cas  out  1 each  active-low strobes.
- mem_address  out  ADDR_W  latched request address.
- mem_datain  out  DATA_W  latched write data.
- mem_dataout  in  DATA_W  registered memory read data; memory drives 0 in any cycle not preceded by an access.

Behaviour:
- Handshake: a request transfers on a posedge with req_valid && req_ready. Address, we and wdata are latched into lat_* registers; inputs are don't-care afterwards.
- Reset (sync):
  - state=IDLE, open_valid=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, lat_*=0.
  - Memory outputs are Moore-decoded from state, so after the reset edge: mem_en=0, mem_rw=0, all strobes=1, mem_address=0, mem_datain=0.
- States: IDLE, VAS, RAS, CAS, ACC, CAPT.
  - IDLE: req_ready=1. On accept: goto VAS unless (PAGE_KEEP && open_valid && v==open_v). Else goto RAS unless (PAGE_KEEP && open_valid && r==open_r). Else goto CAS.
  - VAS: mem_vas=0. Next: RAS, subject to the same skip test on r.
  - RAS: mem_ras=0. Next: CAS.
  - CAS: mem_cas=0, always executed. Next: ACC.
  - ACC: mem_en=1, all strobes=1, mem_rw=lat_we. Write: at the closing edge, rsp_valid<=1, rsp_we<=1, rsp_rdata<=0; goto IDLE. Read: goto CAPT.
  - CAPT: at the closing edge, rsp_valid<=1, rsp_we<=0, rsp_rdata<=mem_dataout; goto IDLE.
- Only one strobe is low in any cycle. mem_address and mem_datain are stable from the VAS/RAS/CAS entry through ACC.
- open_v/open_r are updated at the closing edge of VAS/RAS respectively. open_valid is set once both have been strobed since reset.
- rsp_valid is high for exactly one cycle. There is no backpressure on the response.
- Latency, request accepted at the end of cycle 0:
  - Full-sequence read: rsp_valid in cycle 6.
  - Full-sequence write: rsp_valid in cycle 5.
  - Each skipped strobe subtracts 1 cycle; full page-hit read: rsp_valid in cycle 4.
  - req_ready returns high in the same cycle rsp_valid is high, so back-to-back accept is possible then.
- Reset mid-operation: sequence abandoned, no rsp_valid, open_valid cleared. An aborted write before ACC does not modify memory.
- req_valid while busy: ignored (req_ready=0). The requester must hold it.

Decomposition:
- Package ram32_sdram_pkg holds:
  - state enum: IDLE, VAS, RAS, CAS, ACC, CAPT.
  - field slice constants: V_HI=4, V_LO=3, R_HI=2, R_LO=1, C_BIT=0.
  - default ADDR_W/DATA_W.
- No sub-module: single FSM plus latch/open-page registers. The bench instantiates the controller with ram32_sdram_3split as the memory model.

Test Plan:
- Reset then write addr=5'h13, data=8'hA5 -> strobe order vas,ras,cas in cycles 1-3; mem_en=1 and mem_rw=1 in cycle 4; rsp_valid=1, rsp_we=1 in cycle 5.
- Read addr=5'h13 after that write (same v=2, r=1, PAGE_KEEP=1) -> VAS/RAS skipped, CAS then ACC then CAPT; rsp_rdata=8'hA5 with rsp_valid in cycle 4 after accept.
- Write 5'h00=8'h11 and 5'h1F=8'hEE, read both with PAGE_KEEP=0 -> full sequence each time; data 8'h11 and 8'hEE returned; read rsp_valid in cycle 6.
- Read 5'h02 then 5'h0A (v changes, r same) -> only VAS and CAS strobed for the second; correct data returned.
- Assert rst during RAS of a write to 5'h07=8'h3C, then read 5'h07 -> no rsp for the aborted write; read returns the prior value (8'h00 after init write); full strobe sequence used.
- Hold req_valid continuously with 4 alternating reads/writes -> accepts occur only in IDLE; exactly 4 rsp_valid pulses; no cycle has two strobes low.
